// File: rtl/gpio_input_capture_if.sv
// rtl/gpio_input_capture_if.sv - register-select slave bus shared by the GPIO peripherals
// The read-data line is named dout because "do" is a reserved word.
interface gpio_input_capture_if;
    logic [2:0]  regSel;
    logic        we;
    logic [31:0] di;
    logic [31:0] dout;

    modport master (output regSel, output we, output di, input dout);
    modport slave  (input regSel, input we, input di, output dout);
endinterface

// File: rtl/gpio_input_capture.sv
// rtl/gpio_input_capture.sv - 16-pin input capture: sync, debounce, edge pending, level irq
// Debounced level and edge events are produced on the same clock edge.
module gpio_input_capture #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEB_RESET   = 16'h0000
) (
    input  logic                        clk,
    input  logic                        reset,
    gpio_input_capture_if.slave         bus,
    input  logic [15:0]                 pins,
    output logic                        irq
);
    localparam logic [2:0] A_IN       = 3'b000;
    localparam logic [2:0] A_RISE_EN  = 3'b001;
    localparam logic [2:0] A_FALL_EN  = 3'b010;
    localparam logic [2:0] A_PENDING  = 3'b011;
    localparam logic [2:0] A_DEBOUNCE = 3'b100;

    logic [15:0] r_sync [SYNC_STAGES];
    logic [15:0] r_deb;
    logic [15:0] r_samp;
    logic [15:0] r_presc;
    logic [15:0] r_rise_en;
    logic [15:0] r_fall_en;
    logic [15:0] r_pending;
    logic [15:0] r_debounce;

    logic [15:0] w_sync;
    logic        w_bypass;
    logic        w_strobe;
    logic [15:0] w_stable;
    logic [15:0] w_deb_next;
    logic [15:0] w_rise;
    logic [15:0] w_fall;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_rdata;
    logic        w_wr_deb;
    logic        w_unused_di;

    assign w_unused_di = ^bus.di[31:16];
    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_bypass    = (r_debounce == 16'h0000);
    assign w_strobe    = !w_bypass && (r_presc == r_debounce);
    assign w_wr_deb    = bus.we && (bus.regSel == A_DEBOUNCE);

    // A bit is accepted only when it matched the previous strobe sample too.
    assign w_stable = ~(w_sync ^ r_samp);

    always_comb begin
        w_deb_next = r_deb;
        if (w_bypass)
            w_deb_next = w_sync;
        else if (w_strobe)
            w_deb_next = (r_deb & ~w_stable) | (w_sync & w_stable);
    end

    assign w_rise = ~r_deb & w_deb_next;
    assign w_fall = r_deb & ~w_deb_next;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (bus.we && (bus.regSel == A_PENDING)) ? bus.di[15:0] : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= 16'h0000;
        end else begin
            r_sync[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb      <= 16'h0000;
            r_samp     <= 16'h0000;
            r_presc    <= 16'h0000;
            r_rise_en  <= 16'h0000;
            r_fall_en  <= 16'h0000;
            r_pending  <= 16'h0000;
            r_debounce <= DEB_RESET;
        end else begin
            r_deb <= w_deb_next;
            if (w_strobe)
                r_samp <= w_sync;

            if (w_wr_deb || w_bypass || w_strobe)
                r_presc <= 16'h0000;
            else
                r_presc <= r_presc + 16'd1;

            // Set is ORed after the clear so a simultaneous event wins.
            r_pending <= (r_pending & ~w_clr) | w_set;

            if (bus.we && (bus.regSel == A_RISE_EN))
                r_rise_en <= bus.di[15:0];
            if (bus.we && (bus.regSel == A_FALL_EN))
                r_fall_en <= bus.di[15:0];
            if (w_wr_deb)
                r_debounce <= bus.di[15:0];
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (bus.regSel)
            A_IN:       w_rdata = r_deb;
            A_RISE_EN:  w_rdata = r_rise_en;
            A_FALL_EN:  w_rdata = r_fall_en;
            A_PENDING:  w_rdata = r_pending;
            A_DEBOUNCE: w_rdata = r_debounce;
            default:    w_rdata = 16'h0000;
        endcase
    end

    assign bus.dout = {16'h0000, w_rdata};
    assign irq      = |r_pending;
endmodule
